mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage directly downstream of the execution unit.
- Takes the ALU result as the effective address and rs2 as store data, and performs byte, half or word loads and stores to data memory over a req/ack handshake.
- Sign- or zero-extends load data and holds the core stalled until the access completes.
- Flags misaligned accesses and unresponsive memory.

Parameters:
- TIMEOUT, 255: max cycles waiting for dmem_ack before aborting (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  execution result valid this cycle; sampled only in IDLE
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_unsigned  in  1  zero-extend loads (lbu/lhu)
- alu_result  in  32  effective address from execution unit
- store_data  in  32  rs2 value
- stall  out  1  freeze upstream stages
- done  out  1  one-cycle pulse: access finished, load_data valid
- load_data  out  32  extended load result (0 for stores, pass-through and errors)
- misaligned  out  1  valid with done: alignment fault
- timeout_err  out  1  valid with done: memory never acked
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-steered store data
- dmem_be  out  4  byte enables, little-endian
- dmem_ack  in  1  memory completes request this cycle
- dmem_rdata  in  32  read word, valid with ack

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, done, load_data, misaligned, timeout_err; timeout counter is cleared.
  - stall reads 0 while rst_n=0.
  - Reset mid-ACCESS drops dmem_req at that edge. A late dmem_ack after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, start=1, neither mem_read nor mem_write: go to DONE; no memory request; load_data=0.
- IDLE, start=1, access misaligned: go to DONE; misaligned=1; no request issued.
  - Half is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]!=0.
- IDLE, start=1, valid access:
  - Register dmem_addr, dmem_we, dmem_wdata and dmem_be, plus size, unsigned and the byte offset.
  - Assert dmem_req at the next edge and go to ACCESS.
- mem_read and mem_write both set: perform the write; read is ignored.
- ACCESS:
  - dmem_req and all request fields are held stable until the cycle dmem_ack=1.
  - On ack: deassert dmem_req, capture dmem_rdata through the lane aligner into load_data (reads only), go to DONE.
  - Counter increments each cycle in ACCESS without ack. When it reaches TIMEOUT: drop req, timeout_err=1, go to DONE.
  - Ack in the same cycle the counter hits TIMEOUT: ack wins, no error.
- DONE: done=1 for exactly one cycle with the load_data/misaligned/timeout_err values set on entry; then return to IDLE. Those outputs clear when done falls.
- Latency:
  - Zero-wait memory: start at cycle 0, dmem_req high cycle 1, ack cycle 1, done cycle 2.
  - n wait cycles add n.
  - Pass-through and misaligned: done at cycle 1.
- stall (combinational) = (IDLE & start & (mem_read|mem_write)) | ACCESS. It is low in DONE.
- start outside IDLE is ignored. dmem_ack outside ACCESS is ignored.
- Store lane steering:
  - Byte: store_data[7:0] replicated to all 4 lanes; be=4'b0001<<addr[1:0].
  - Half: store_data[15:0] to both halves; be=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - Word: store_data as-is; be=1111.
- Load extract:
  - Byte lane = rdata[8*off+7:8*off].
  - Half lane = rdata[16*addr[1]+15:16*addr[1]].
  - Selected lane is sign-extended from its MSB unless load_unsigned.
- Loads drive dmem_be=1111; the memory ignores be on reads.

Decomposition:
- Package mips_mem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State encoding IDLE/ACCESS/DONE.
  - Default TIMEOUT constant.
- Sub-module mem_lane_align, purely combinational:
  - Store path: store steering and be generation.
  - Load path: lane extraction and sign/zero extension.
  - Instantiated once and shared by both paths.

Test Plan:
- Word store, zero-wait: alu_result=0x100, store_data=0xDEADBEEF, mem_write, size=10, ack on first req cycle -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; done at cycle 2; stall high cycles 0-1.
- Byte store and loads, 2 wait cycles: sb 0xA5 to 0x103 -> be=1000, wdata=0xA5A5A5A5. Then rdata=0xA5000000 at 0x103:
  - lb -> load_data=0xFFFFFFA5.
  - lbu -> load_data=0x000000A5.
  - done 2 cycles later than zero-wait.
- Half load: lh at 0x102, rdata=0x80017FFF -> load_data=0xFFFF8001; lhu -> 0x00008001.
- Misaligned: lw at 0x101 -> no dmem_req ever; done cycle 1 with misaligned=1, load_data=0.
- Timeout: TIMEOUT=4, no ack -> req held 4 cycles then drops; done with timeout_err=1. Repeat with ack on the 4th cycle -> no error.
- Reset mid-ACCESS: rst_n=0 during a wait -> next edge dmem_req=0, done=0, stall=0. A late ack is ignored, and the next start behaves normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the memory access stage.
package mips_mem_pkg;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  // Attributes of the in-flight access needed when the read data returns.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       rd;
  } access_t;

  // Alignment fault: half on odd byte, word (or reserved size) off a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data memory req/ack bus between the access unit and data memory.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extract + extension for loads.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] ldata
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  // Word (and reserved size) passes straight through; narrower sizes steer lanes.
  always_comb begin
    wdata  = store_data;
    be     = 4'hF;
    ldata  = rdata;
    b_lane = rdata[{off, 3'b000} +: 8];
    h_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << off;
        ldata = {{24{b_lane[7] & ~uns}}, b_lane};
      end
      SZ_HALF: begin
        wdata = {2{store_data[15:0]}};
        be    = off[1] ? 4'b1100 : 4'b0011;
        ldata = {{16{h_lane[15] & ~uns}}, h_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues loads/stores over req/ack, stalls upstream until done.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout_err,
  mem_access_unit_if.master dmem
);

  state_e      state, state_n;
  access_t     acc;
  logic [7:0]  cnt;
  logic        is_mem, mis_in, go, to_hit;
  logic [1:0]  al_size, al_off;
  logic        al_uns;
  logic [31:0] al_wdata, al_ldata;
  logic [3:0]  al_be;

  assign is_mem = mem_read | mem_write;
  assign mis_in = is_misaligned(size, alu_result[1:0]);
  assign go     = start & is_mem & ~mis_in;
  assign to_hit = (cnt == 8'(TIMEOUT - 1));

  // One aligner: fed live inputs while idle (store steering), latched access while waiting (load extract).
  assign al_size = (state == IDLE) ? size              : acc.size;
  assign al_off  = (state == IDLE) ? alu_result[1:0]   : acc.off;
  assign al_uns  = (state == IDLE) ? load_unsigned     : acc.uns;

  mem_lane_align u_align (
    .size       (al_size),
    .off        (al_off),
    .uns        (al_uns),
    .store_data (store_data),
    .rdata      (dmem.rdata),
    .wdata      (al_wdata),
    .be         (al_be),
    .ldata      (al_ldata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and upstream stall; ack beats a simultaneous timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = go ? ACCESS : DONE;
      ACCESS:  if (dmem.ack || to_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    stall = rst_n & (((state == IDLE) & start & is_mem) | (state == ACCESS));
  end

  // Request fields, wait counter and result registers valid for the one DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      dmem.be     <= '0;
      done        <= 1'b0;
      load_data   <= '0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      dmem.req    <= (state_n == ACCESS);
      done        <= (state_n == DONE);
      load_data   <= '0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            misaligned <= is_mem & mis_in;
            if (go) begin
              dmem.addr  <= {alu_result[31:2], 2'b00};
              dmem.we    <= mem_write;
              dmem.wdata <= mem_write ? al_wdata : 32'h0;
              dmem.be    <= mem_write ? al_be : 4'hF;
              acc        <= '{size: size, uns: load_unsigned, off: alu_result[1:0],
                              rd: mem_read & ~mem_write};
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          if (dmem.ack) begin
            if (acc.rd) load_data <= al_ldata;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with an in-bench memory and reference model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        stall, done, misaligned, timeout_err;
  logic [31:0] load_data;
  int          vectors = 0, miscompares = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .size          (size),
    .load_unsigned (load_unsigned),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .stall         (stall),
    .done          (done),
    .load_data     (load_data),
    .misaligned    (misaligned),
    .timeout_err   (timeout_err),
    .dmem          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick lane arithmetically, sign-extend by subtracting 2^bits when MSB set.
  function automatic logic [31:0] m_load(input int sz, input bit uns, input int off, input logic [31:0] rd);
    int unsigned bits;
    logic [31:0] lane;
    if (sz == 0)      begin bits = 8;  lane = (rd >> (8 * off)) & 32'hFF; end
    else if (sz == 1) begin bits = 16; lane = (rd >> (16 * (off / 2))) & 32'hFFFF; end
    else return rd;
    if (!uns && lane >= (32'd1 << (bits - 1))) lane = lane - (32'd1 << bits);
    return lane;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] sd);
    if (sz == 0) return (sd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int off);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'hF;
  endfunction

  function automatic bit m_mis(input int sz, input int off);
    if (sz == 0) return 1'b0;
    if (sz == 1) return (off % 2) != 0;
    return off != 0;
  endfunction

  // One access: waits = req cycles before ack (>= TO means memory never acks).
  task automatic run_access(input bit rd, input bit wr, input int sz, input bit uns,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int waits, input string tag);
    int off, exp_done, exp_req, req_n, dc;
    bit is_mem, mis, acc, timed, got;
    logic [31:0] exp_ld;
    logic [3:0]  exp_be;
    off      = int'(addr % 4);
    is_mem   = rd | wr;
    mis      = is_mem && m_mis(sz, off);
    acc      = is_mem && !mis;
    timed    = acc && (waits >= TO);
    exp_done = !acc ? 1 : (timed ? TO + 1 : waits + 2);
    exp_req  = !acc ? 0 : (timed ? TO : waits + 1);
    exp_ld   = (acc && rd && !wr && !timed) ? m_load(sz, uns, off, rdata) : 32'h0;
    exp_be   = wr ? m_be(sz, off) : 4'hF;

    @(negedge clk);
    start = 1'b1; mem_read = rd; mem_write = wr; size = 2'(sz);
    load_unsigned = uns; alu_result = addr; store_data = sd;
    #1 chk({tag, ".stall0"}, 64'(stall), 64'(is_mem));

    req_n = 0; got = 1'b0; dc = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble inputs: the request must come from registered copies.
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = $urandom; store_data = $urandom; size = 2'($urandom);
      end
      bus.ack = 1'b0;
      #1;
      chk({tag, ".stall"}, 64'(stall), 64'(acc && c < exp_done));
      if (bus.req) begin
        chk({tag, ".req"}, {bus.we, bus.be, bus.addr}, {wr, exp_be, addr & 32'hFFFFFFFC});
        if (wr) chk({tag, ".wdata"}, 64'(bus.wdata), 64'(m_wdata(sz, sd)));
        if (req_n == waits) begin bus.ack = 1'b1; bus.rdata = rdata; end
        else bus.rdata = $urandom;
        req_n++;
      end
      if (done) begin
        got = 1'b1; dc = c;
        chk({tag, ".ld"}, 64'(load_data), 64'(exp_ld));
        chk({tag, ".flags"}, {misaligned, timeout_err}, {mis, timed});
      end
    end
    bus.ack = 1'b0;
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(dc), 64'(exp_done));
    chk({tag, ".req_cycles"}, 64'(req_n), 64'(exp_req));
    @(negedge clk); #1;
    chk({tag, ".after"}, {done, misaligned, timeout_err, load_data}, 64'h0);
  endtask

  initial begin
    bus.ack = 1'b0; bus.rdata = '0;
    // Reset state, including stall held low with a pending load request.
    start = 1'b1; mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {bus.req, bus.we, bus.be, done, misaligned, timeout_err, stall}, 64'h0);
    chk("rst_addr", 64'(bus.addr), 64'h0);
    chk("rst_wdata", 64'(bus.wdata), 64'h0);
    chk("rst_ld", 64'(load_data), 64'h0);
    start = 1'b0; mem_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    run_access(0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, "sw0");
    run_access(0, 1, 0, 0, 32'h103, 32'h000000A5, 32'h0, 2, "sb");
    run_access(1, 0, 0, 0, 32'h103, 32'h0, 32'hA5000000, 2, "lb");
    run_access(1, 0, 0, 1, 32'h103, 32'h0, 32'hA5000000, 2, "lbu");
    run_access(1, 0, 1, 0, 32'h102, 32'h0, 32'h80017FFF, 0, "lh");
    run_access(1, 0, 1, 1, 32'h102, 32'h0, 32'h80017FFF, 0, "lhu");
    run_access(1, 0, 2, 0, 32'h101, 32'h0, 32'h12345678, 0, "lw_mis");
    run_access(0, 1, 1, 0, 32'h203, 32'h5555, 32'h0, 0, "sh_mis");
    run_access(1, 0, 2, 0, 32'h200, 32'h0, 32'hCAFEF00D, 99, "lw_to");
    run_access(1, 0, 2, 0, 32'h200, 32'h0, 32'hCAFEF00D, TO - 1, "lw_ack_at_to");
    run_access(0, 0, 2, 0, 32'h300, 32'h0, 32'h0, 0, "pass");
    run_access(1, 1, 1, 0, 32'h306, 32'hBEEF1234, 32'hFFFFFFFF, 1, "rdwr");
    run_access(1, 0, 3, 0, 32'h310, 32'h0, 32'h89ABCDEF, 0, "lw_rsvd");

    // Reset in the middle of a waiting load; a late ack must be ignored.
    @(negedge clk);
    start = 1'b1; mem_read = 1'b1; size = SZ_WORD; alu_result = 32'h40;
    @(negedge clk); start = 1'b0; mem_read = 1'b0;
    #1 chk("mid.req_before", 64'(bus.req), 64'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("mid.stall_in_rst", 64'(stall), 64'd0);
    @(negedge clk); #1;
    chk("mid.after_rst", {bus.req, done, stall}, 64'h0);
    rst_n = 1'b1; bus.ack = 1'b1; bus.rdata = 32'h77777777;
    @(negedge clk); bus.ack = 1'b0; #1;
    chk("mid.late_ack", {bus.req, done, stall, load_data}, 64'h0);
    run_access(1, 0, 0, 0, 32'h41, 32'h0, 32'h0000F000, 1, "mid.next");

    // Randomized accesses, including timeouts and reserved size.
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                 $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
